// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, working-state type, mode/FSM encodings and round functions.
// Pure package: no timing or flow control of its own.
package sha256_pkg;

   typedef enum logic [1:0] {
      MODE_HASH = 2'd0,
      MODE_INIT = 2'd1,
      MODE_RSVD = 2'd2,
      MODE_REDO = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
      logic [31:0] e;
      logic [31:0] f;
      logic [31:0] g;
      logic [31:0] h;
   } work_t;

   localparam work_t IV = work_t'(256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic logic [31:0] Sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] Sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Word-wise modulo-2^32 sum, no carry between words.
   function automatic work_t add_state(input work_t x, input work_t y);
      logic [255:0] xv, yv, s;
      xv = x;
      yv = y;
      s  = '0;
      for (int i = 0; i < 8; i++) begin
         s[32*i +: 32] = xv[32*i +: 32] + yv[32*i +: 32];
      end
      return work_t'(s);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
// Zero latency, no flow control.
module sha256_round
   import sha256_pkg::*;
(
   input  work_t       state_in,
   input  logic [31:0] w,
   input  logic [31:0] k,
   output work_t       state_out
);

   logic [31:0] t1;
   logic [31:0] t2;

   always_comb begin
      t1 = state_in.h + Sigma1(state_in.e) + ch(state_in.e, state_in.f, state_in.g) + k + w;
      t2 = Sigma0(state_in.a) + maj(state_in.a, state_in.b, state_in.c);
      state_out.a = t1 + t2;
      state_out.b = state_in.a;
      state_out.c = state_in.b;
      state_out.d = state_in.c;
      state_out.e = state_in.d + t1;
      state_out.f = state_in.e;
      state_out.g = state_in.f;
      state_out.h = state_in.g;
   end

endmodule

// File: rtl/sha_core_param.sv
// Iterative SHA-256 block core, RPC rounds per clock, digest held until out_ready.
// Latency 64/RPC+1 clocks incl. acceptance edge; accepts one block only when idle.
module sha_core_param
   import sha256_pkg::*;
#(
   parameter int RPC     = 1,
   parameter bit OUT_REG = 1'b1
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   mode,
   input  logic [511:0] message,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] hash,
   output logic         busy
);

   localparam int CYCLES = 64 / RPC;
   localparam int CNT_W  = $clog2(CYCLES);

   if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
      $error("sha_core_param: RPC must be 1, 2, 4, 8 or 16");
   end

   fsm_t             state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             rdy_q;
   logic [1:0]       mode_q;
   work_t            h_q, start_q, work_q, digest_q;
   work_t            start_sel, sum, run_out;
   logic [31:0]      win_q    [16];
   logic [31:0]      win_next [16];
   logic [5:0]       base_idx;
   logic             accept, last_round;

   // rdy_q keeps in_ready low until the first edge after reset release.
   assign in_ready   = rdy_q && (state_q == ST_IDLE);
   assign accept     = in_valid && in_ready;
   assign last_round = (cnt_q == CNT_W'(CYCLES - 1));
   assign out_valid  = (state_q == ST_DONE);
   assign busy       = (state_q != ST_IDLE);
   assign start_sel  = (mode == MODE_INIT) ? IV : h_q;
   assign sum        = add_state(start_q, work_q);
   assign base_idx   = 6'(cnt_q * RPC);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)     state_d = ST_RUN;
         ST_RUN:  if (last_round) state_d = ST_DONE;
         ST_DONE: if (out_ready)  state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   // Message schedule: current window plus RPC freshly expanded words.
   for (genvar i = 0; i < 16 + RPC; i++) begin : g_w
      logic [31:0] w;
      if (i < 16) begin : g_win
         assign w = win_q[i];
      end else begin : g_ext
         assign w = sigma1(g_w[i-2].w) + g_w[i-7].w + sigma0(g_w[i-15].w) + g_w[i-16].w;
      end
   end

   for (genvar i = 0; i < 16; i++) begin : g_slide
      assign win_next[i] = g_w[i+RPC].w;
   end

   for (genvar j = 0; j < RPC; j++) begin : g_round
      work_t      st_in, st_out;
      logic [5:0] k_idx;
      if (j == 0) begin : g_first
         assign st_in = work_q;
      end else begin : g_next
         assign st_in = g_round[j-1].st_out;
      end
      assign k_idx = base_idx + 6'(j);
      sha256_round u_round (
         .state_in  (st_in),
         .w         (g_w[j].w),
         .k         (K[k_idx]),
         .state_out (st_out)
      );
   end

   assign run_out = g_round[RPC-1].st_out;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_q    <= 1'b0;
         cnt_q    <= '0;
         mode_q   <= MODE_HASH;
         h_q      <= IV;
         start_q  <= '0;
         work_q   <= '0;
         digest_q <= '0;
         for (int i = 0; i < 16; i++) win_q[i] <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (accept) begin
            mode_q  <= mode;
            start_q <= start_sel;
            work_q  <= start_sel;
            cnt_q   <= '0;
            for (int i = 0; i < 16; i++) win_q[i] <= message[511-32*i -: 32];
         end else if (state_q == ST_RUN) begin
            cnt_q  <= cnt_q + 1'b1;
            work_q <= run_out;
            for (int i = 0; i < 16; i++) win_q[i] <= win_next[i];
            if (last_round) digest_q <= add_state(start_q, run_out);
         end
         // REDO leaves the chaining value untouched.
         if (out_valid && out_ready && (mode_q != MODE_REDO)) h_q <= sum;
      end
   end

   if (OUT_REG) begin : g_out_reg
      assign hash = digest_q;
   end else begin : g_out_comb
      assign hash = out_valid ? sum : '0;
   end

endmodule

// File: tb/tb_sha_core_param.sv
// Directed + random bench for sha_core_param at RPC 1, 4 (combinational output) and 16,
// checked against an arithmetic SHA-256 model with constants derived from prime roots.
module tb_sha_core_param;

   localparam int ND = 3;

   localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMP_BLK = {32'h80000000, 480'h0};
   localparam logic [511:0] B1_BLK  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] B2_BLK  = {480'h0, 32'h000001c0};

   localparam logic [255:0] KAT_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] KAT_EMP = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] KAT_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   logic         clk = 1'b0;
   logic         rst       [ND];
   logic         in_valid  [ND];
   logic         in_ready  [ND];
   logic [1:0]   mode      [ND];
   logic [511:0] message   [ND];
   logic         out_valid [ND];
   logic         out_ready [ND];
   logic [255:0] hash      [ND];
   logic         busy      [ND];

   int           checks = 0;
   int           errors = 0;
   logic [31:0]  kt [64];
   logic [255:0] ivt;
   logic [255:0] h_model [ND];

   always #5 clk = ~clk;

   sha_core_param #(.RPC(1), .OUT_REG(1'b1)) u_dut0 (
      .clk(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .mode(mode[0]),
      .message(message[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .hash(hash[0]), .busy(busy[0]));
   sha_core_param #(.RPC(4), .OUT_REG(1'b0)) u_dut1 (
      .clk(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .mode(mode[1]),
      .message(message[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .hash(hash[1]), .busy(busy[1]));
   sha_core_param #(.RPC(16), .OUT_REG(1'b1)) u_dut2 (
      .clk(clk), .reset(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .mode(mode[2]),
      .message(message[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .hash(hash[2]), .busy(busy[2]));

   function automatic int rpc_of(input int d);
      return (d == 0) ? 1 : (d == 1) ? 4 : 16;
   endfunction

   // floor(root(p) * 2^32) mod 2^32 by exact integer bisection.
   function automatic logic [31:0] frac_root(input int p, input int deg);
      logic [127:0] y, t, pw, target;
      target = (deg == 3) ? (128'(p) << 96) : (128'(p) << 64);
      y = '0;
      for (int b = 40; b >= 0; b--) begin
         t  = y | (128'(1) << b);
         pw = (deg == 3) ? t * t * t : t * t;
         if (pw <= target) y = t;
      end
      return y[31:0];
   endfunction

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] hv [8];
      logic [31:0] t1, t2;
      logic [255:0] r;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int i = 0; i < 8; i++) begin
         hv[i] = hin[255-32*i -: 32];
         v[i]  = hv[i];
      end
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[t] + w[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      r = '0;
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[i] + v[i];
      return r;
   endfunction

   function automatic logic [511:0] rand_block();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input int d, input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL d%0d_%s observed %h expected %h", d, tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input int d, input string tag);
      chk(d, {tag, "_in_ready"}, in_ready[d], 0);
      chk(d, {tag, "_out_valid"}, out_valid[d], 0);
      chk(d, {tag, "_busy"}, busy[d], 0);
      chk(d, {tag, "_hash"}, hash[d], 0);
   endtask

   task automatic release_reset(input int d);
      repeat (2) @(negedge clk);
      chk(d, "rst_held_in_ready", in_ready[d], 0);
      rst[d] = 1'b1;
      #1;
      chk(d, "rst_released_in_ready", in_ready[d], 0);
      @(posedge clk);
      #1;
      chk(d, "rst_first_edge_in_ready", in_ready[d], 1);
      h_model[d] = ivt;
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
   endtask

   task automatic run_block(input int d, input logic [1:0] md, input logic [511:0] msg,
                            input int hold, output logic [255:0] got);
      logic [255:0] exp;
      int n;
      int cyc;
      cyc = 64 / rpc_of(d);
      exp = ref_compress((md == 2'd1) ? ivt : h_model[d], msg);
      if (md != 2'd3) h_model[d] = exp;
      @(negedge clk);
      chk(d, "idle_in_ready", in_ready[d], 1);
      in_valid[d]  = 1'b1;
      mode[d]      = md;
      message[d]   = msg;
      out_ready[d] = (hold == 0);
      @(posedge clk);
      n = 1;
      while (n < cyc + 20) begin
         @(negedge clk);
         if (out_valid[d]) break;
         if (n == 2) begin
            chk(d, "run_busy", busy[d], 1);
            chk(d, "run_in_ready", in_ready[d], 0);
            in_valid[d] = 1'b1;
            mode[d]     = 2'd1;
            message[d]  = rand_block();
         end else begin
            in_valid[d] = 1'b0;
         end
         @(posedge clk);
         n++;
      end
      in_valid[d] = 1'b0;
      chk(d, "out_valid_seen", out_valid[d], 1);
      chk(d, "latency", n, cyc + 1);
      got = hash[d];
      chk(d, "digest", got, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk(d, "hold_out_valid", out_valid[d], 1);
         chk(d, "hold_hash", hash[d], exp);
         chk(d, "hold_in_ready", in_ready[d], 0);
      end
      out_ready[d] = 1'b1;
      @(negedge clk);
      chk(d, "after_out_valid", out_valid[d], 0);
      chk(d, "after_busy", busy[d], 0);
      chk(d, "after_in_ready", in_ready[d], 1);
   endtask

   task automatic throughput(input int d);
      int cyc, ci, first, second, n;
      cyc = 64 / rpc_of(d);
      first = -1;
      second = -1;
      ci = 0;
      @(negedge clk);
      in_valid[d]  = 1'b1;
      mode[d]      = 2'd1;
      message[d]   = ABC_BLK;
      out_ready[d] = 1'b1;
      while (second < 0 && ci < 400) begin
         if (in_ready[d]) begin
            if (first < 0) first = ci;
            else           second = ci;
         end
         if (out_valid[d]) chk(d, "tput_hash", hash[d], KAT_ABC);
         @(posedge clk);
         #1;
         ci++;
         if (second >= 0) in_valid[d] = 1'b0;
         @(negedge clk);
      end
      in_valid[d] = 1'b0;
      chk(d, "tput_period", second - first, cyc + 2);
      h_model[d] = KAT_ABC;
      n = 0;
      while (!out_valid[d] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(d, "tput_second_valid", out_valid[d], 1);
      chk(d, "tput_second_hash", hash[d], KAT_ABC);
      @(negedge clk);
      chk(d, "tput_idle", busy[d], 0);
   endtask

   initial begin
      int p [64];
      int cnt, cand, cyc, n;
      logic [255:0] got, two_abc;
      bit is_p;

      for (int d = 0; d < ND; d++) begin
         rst[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b1; mode[d] = 2'd0; message[d] = '0;
      end

      cnt = 0;
      cand = 2;
      while (cnt < 64) begin
         is_p = 1'b1;
         for (int q = 2; q * q <= cand; q++) if (cand % q == 0) is_p = 1'b0;
         if (is_p) begin p[cnt] = cand; cnt++; end
         cand++;
      end
      for (int t = 0; t < 64; t++) kt[t] = frac_root(p[t], 3);
      for (int i = 0; i < 8; i++) ivt[255-32*i -: 32] = frac_root(p[i], 2);
      two_abc = ref_compress(ref_compress(ivt, ABC_BLK), B2_BLK);

      for (int d = 0; d < ND; d++) begin
         cyc = 64 / rpc_of(d);
         #1;
         check_reset_outputs(d, "por");
         release_reset(d);

         run_block(d, 2'd1, ABC_BLK, 0, got);
         chk(d, "kat_abc", got, KAT_ABC);
         run_block(d, 2'd1, EMP_BLK, 0, got);
         chk(d, "kat_empty", got, KAT_EMP);
         run_block(d, 2'd1, B1_BLK, 0, got);
         run_block(d, 2'd0, B2_BLK, 0, got);
         chk(d, "kat_two_block", got, KAT_TWO);

         run_block(d, 2'd1, ABC_BLK, 0, got);
         run_block(d, 2'd3, rand_block(), 0, got);
         run_block(d, 2'd3, rand_block(), 10, got);
         run_block(d, 2'd0, B2_BLK, 0, got);
         chk(d, "redo_keeps_h", got, two_abc);

         run_block(d, 2'd3, rand_block(), 0, got);
         run_block(d, 2'd1, ABC_BLK, 0, got);
         chk(d, "init_after_redo", got, KAT_ABC);

         for (int r = 0; r < 4; r++) begin
            run_block(d, 2'($urandom_range(0, 3)), rand_block(), (r == 1) ? 3 : 0, got);
         end

         throughput(d);

         // Reset in the middle of RUN.
         @(negedge clk);
         in_valid[d] = 1'b1; mode[d] = 2'd1; message[d] = rand_block();
         @(posedge clk);
         #1;
         in_valid[d] = 1'b0;
         repeat (cyc / 2) @(posedge clk);
         #1;
         rst[d] = 1'b0;
         #1;
         check_reset_outputs(d, "mid_run");
         release_reset(d);
         run_block(d, 2'd0, ABC_BLK, 0, got);
         chk(d, "post_run_rst_hash_iv", got, KAT_ABC);
         run_block(d, 2'd1, ABC_BLK, 0, got);
         chk(d, "post_run_rst_init", got, KAT_ABC);

         // Reset while the digest is waiting in DONE.
         @(negedge clk);
         in_valid[d] = 1'b1; mode[d] = 2'd0; message[d] = rand_block(); out_ready[d] = 1'b0;
         @(posedge clk);
         n = 0;
         while (n < 200) begin
            @(negedge clk);
            in_valid[d] = 1'b0;
            n++;
            if (out_valid[d]) break;
         end
         chk(d, "done_reached", out_valid[d], 1);
         #1;
         rst[d] = 1'b0;
         #1;
         check_reset_outputs(d, "mid_done");
         release_reset(d);
         run_block(d, 2'd0, ABC_BLK, 0, got);
         chk(d, "post_done_rst_hash_iv", got, KAT_ABC);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sha_core_param.md
SHA_CORE_PARAM -- requirements
Module: sha_core_param

Interface
REQ-001 Parameter RPC, default 1, SHA-256 rounds computed per clock; legal values 1, 2, 4, 8, 16.
REQ-002 Parameter OUT_REG, default 1, 1 = digest output held in a register, 0 = digest output combinational from the adder.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  message block offered.
REQ-006 in_ready  output  1  core can accept a block this cycle.
REQ-007 mode  input  2  0 = HASH, 1 = INIT, 3 = REDO, 2 = reserved (treated as HASH).
REQ-008 message  input  512  block words W0..W15, W0 in bits [511:480].
REQ-009 out_valid  output  1  digest available.
REQ-010 out_ready  input  1  consumer accepts the digest.
REQ-011 hash  output  256  digest H0..H7, H0 in bits [255:224].
REQ-012 busy  output  1  FSM not in IDLE.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE SHALL assert in_ready; in_valid&in_ready SHALL latch message, mode and the start state, then go to RUN with the round counter at 0.
REQ-015 Start state SHALL be the SHA-256 IV when mode=INIT, and the chaining register H otherwise.
REQ-016 RUN SHALL apply rounds RPC*n..RPC*n+RPC-1 at counter n; the counter SHALL increment each cycle, and RUN SHALL go to DONE after CYCLES=64/RPC cycles.
REQ-017 Wt SHALL come from a 16-word sliding window advanced RPC words per RUN cycle; Kt SHALL be indexed by round number (ROM), not by a rotating register.
REQ-018 DONE SHALL assert out_valid with hash = start state + working state (mod 2^32 per word) and hold it stable until out_valid&out_ready, then go to IDLE.
REQ-019 On exit from DONE, H SHALL be updated to the digest for INIT and HASH, and left unchanged for REDO.
REQ-020 Latency SHALL be CYCLES+1 clocks from the acceptance edge to out_valid high; throughput SHALL be one block per CYCLES+2 clocks when out_ready is held high.
REQ-021 in_ready SHALL be 0 in RUN and DONE; in_valid outside IDLE SHALL be ignored, with no state change.
REQ-022 out_valid&out_ready in the same cycle that DONE is entered SHALL be honoured, and IDLE SHALL follow on the next edge.
REQ-023 Mode=INIT SHALL never read the stale H, so an INIT after a REDO SHALL be independent of prior blocks.
REQ-024 All additions SHALL be 32-bit wrap-around with no carry out.
REQ-025 If OUT_REG=1, out_valid and hash SHALL both change only on clock edges.

Reset
REQ-026 Assertion of reset SHALL force IDLE, in_ready=0 while asserted, out_valid=0, busy=0, hash=0, counter=0, and H=IV, independent of clk.
REQ-027 Reset mid-RUN or mid-DONE SHALL discard the block with no partial H update.
REQ-028 in_ready SHALL rise on the first clock edge after reset deasserts.

Structure
REQ-029 A shared package sha256_pkg SHALL hold the IV constant, the 64-entry K table, the mode enum, and the functions ch, maj, Sigma0, Sigma1, sigma0 and sigma1.
REQ-030 Sub-module sha256_round SHALL be one combinational round (state, Wt, Kt in; state out), instantiated RPC times in a generate chain.
REQ-031 An elaboration-time check SHALL reject illegal RPC values.

Verification
REQ-032 INIT, single padded block "abc" (61626380, zeros, W15=00000018) -> ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-033 INIT, empty string (80000000, zeros) -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-034 INIT block 1 then HASH block 2 of the 448-bit "abcdbcdecdefdefg...nopq" message -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-035 After "abc" INIT, REDO block 2 twice with different data, then HASH block 2 -> result equals the plain two-block hash, confirming H was unchanged by REDO.
REQ-036 out_ready low for 10 cycles in DONE -> hash and out_valid held stable and in_ready=0 throughout; in_valid pulsed during RUN -> ignored.
REQ-037 reset asserted at counter=CYCLES/2 -> outputs at reset values immediately; a following "abc" INIT gives the correct digest; run for RPC = 1, 4 and 16, checking latency = CYCLES+1.
